// File: rtl/fp_stream_accumulator.sv
// Stream sequencer around an external combinational single-precision add/sub unit.
// Operands arrive over valid/ready; the running sum is presented with its element count.
module fp_stream_accumulator #(
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_s,
    input  logic [31:0]      add_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    localparam int unsigned WAIT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        ADD    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_r;
    logic [31:0]        acc_r;
    logic               acc_zero_r;
    logic [CNT_W-1:0]   count_r;
    logic [31:0]        op_r;
    logic               sub_r;
    logic               last_r;
    logic [WAIT_W-1:0]  wait_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [31:0]        out_data_r;
    logic [CNT_W-1:0]   out_count_r;
    logic               busy_r;

    logic [31:0]        acc_next_s;
    logic               acc_zero_next_s;
    logic               add_final_s;

    assign add_final_s = (wait_r == WAIT_W'(ADD_LAT - 1));

    // Accumulator update rule: skip denormal/zero operands, bypass the adder on an empty sum,
    // and flush adder results that land in the denormal range to +0.
    always_comb begin
        acc_next_s      = acc_r;
        acc_zero_next_s = acc_zero_r;
        if (op_r[30:23] == 8'd0) begin
            acc_next_s      = acc_r;
            acc_zero_next_s = acc_zero_r;
        end else if (acc_zero_r) begin
            acc_next_s      = {op_r[31] ^ sub_r, op_r[30:0]};
            acc_zero_next_s = 1'b0;
        end else if (add_o[30:23] == 8'd0) begin
            acc_next_s      = 32'h0000_0000;
            acc_zero_next_s = 1'b1;
        end else begin
            acc_next_s      = add_o;
            acc_zero_next_s = 1'b0;
        end
    end

    // Sequencer FSM with all handshake/status outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= 32'h0000_0000;
            acc_zero_r  <= 1'b1;
            count_r     <= '0;
            op_r        <= 32'h0000_0000;
            sub_r       <= 1'b0;
            last_r      <= 1'b0;
            wait_r      <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h0000_0000;
            out_count_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r      <= 32'h0000_0000;
                        acc_zero_r <= 1'b1;
                        count_r    <= '0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ACCEPT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        op_r       <= in_data;
                        sub_r      <= in_sub;
                        last_r     <= in_last;
                        if (count_r != {CNT_W{1'b1}}) begin
                            count_r <= count_r + CNT_W'(1);
                        end else begin
                            count_r <= count_r;
                        end
                        wait_r     <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= ADD;
                    end else begin
                        state_r <= ACCEPT;
                    end
                end
                ADD: begin
                    if (add_final_s) begin
                        acc_r      <= acc_next_s;
                        acc_zero_r <= acc_zero_next_s;
                        if (last_r) begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= acc_next_s;
                            out_count_r <= count_r;
                            state_r     <= DONE;
                        end else begin
                            in_ready_r <= 1'b1;
                            state_r    <= ACCEPT;
                        end
                    end else begin
                        wait_r <= wait_r + WAIT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_count = out_count_r;
    assign busy      = busy_r;
    assign add_a     = acc_r;
    assign add_b     = op_r;
    assign add_s     = sub_r;

endmodule
